// File: rtl/jtbubl_pkg.sv
// Shared constants for the JTBUBL interrupt/watchdog block.
package jtbubl_pkg;

    localparam logic IRQ_LATCH = 1'b0;
    localparam logic IRQ_PULSE = 1'b1;

    typedef enum logic {
        WD_RUN  = 1'b0,
        WD_HOLD = 1'b1
    } wd_state_e;

endpackage

// File: rtl/jtbubl_irq_chan.sv
// One interrupt channel: cen-sampled rising-edge detect, then either a latch
// cleared by ack or a 2^PW cen-tick pulse.
module jtbubl_irq_chan
    import jtbubl_pkg::*;
#(
    parameter int unsigned PW = 4
) (
    input  logic clk24,
    input  logic rst,
    input  logic cen_i,
    input  logic src_i,
    input  logic mode_i,
    input  logic ack_i,
    output logic irq_n_o
);

    logic          last_q, last_d;
    logic          active_q, active_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          rise;

    assign rise    = cen_i & src_i & ~last_q;
    assign irq_n_o = ~active_q;

    always_comb begin
        last_d   = cen_i ? src_i : last_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        if (mode_i == IRQ_LATCH) begin
            if (ack_i) active_d = 1'b0;
        end else if (cen_i && active_q) begin
            if (&cnt_q) active_d = 1'b0;
            else        cnt_d    = cnt_q + PW'(1);
        end
        // A fresh edge overrides a same-cycle ack and restarts a running pulse
        if (rise) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            last_q   <= last_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/jtbubl_irq_wdog.sv
// Interrupt generator plus frame watchdog with held, self-releasing CPU reset.
// Define JTBUBL_WDOG_EN to build the watchdog; otherwise wdog_rst_n follows rst only.
module jtbubl_irq_wdog
    import jtbubl_pkg::*;
#(
    parameter int unsigned NIRQ = 3,
    parameter int unsigned PW   = 4,
    parameter int unsigned WW   = 8,
    parameter int unsigned HOLD = 4
) (
    input  logic            clk24,
    input  logic            rst,
    input  logic            cen,
    input  logic            LVBL,
    input  logic            wdog_clr,
    input  logic [NIRQ-1:0] irq_src,
    input  logic [NIRQ-1:0] irq_mode,
    input  logic [NIRQ-1:0] irq_ack,
    output logic [NIRQ-1:0] irq_n,
    output logic            wdog_rst_n,
    output logic [WW-1:0]   wdog_cnt
);

    for (genvar i = 0; i < NIRQ; i++) begin : g_chan
        jtbubl_irq_chan #(
            .PW(PW)
        ) u_chan (
            .clk24   (clk24),
            .rst     (rst),
            .cen_i   (cen),
            .src_i   (irq_src[i]),
            .mode_i  (irq_mode[i]),
            .ack_i   (irq_ack[i]),
            .irq_n_o (irq_n[i])
        );
    end

    logic rstn_q, rstn_d;

    assign wdog_rst_n = rstn_q;

`ifdef JTBUBL_WDOG_EN
    wd_state_e     state_q, state_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] hold_q, hold_d;
    logic          lvbl_q;
    logic          tick;

    assign tick     = LVBL & ~lvbl_q;
    assign wdog_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rstn_d  = 1'b1;
        unique case (state_q)
            WD_RUN: begin
                if (wdog_clr)  cnt_d = '0;
                else if (tick) cnt_d = cnt_q + WW'(1);
                // MSB set means the frame limit was reached; counter never wraps
                if (cnt_d[WW-1]) begin
                    state_d = WD_HOLD;
                    rstn_d  = 1'b0;
                end
            end
            WD_HOLD: begin
                rstn_d = 1'b0;
                if (tick) begin
                    hold_d = hold_q + WW'(1);
                    if (hold_d == WW'(HOLD)) begin
                        cnt_d   = '0;
                        hold_d  = '0;
                        state_d = WD_RUN;
                        rstn_d  = 1'b1;
                    end
                end
            end
            default: state_d = WD_RUN;
        endcase
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            state_q <= WD_RUN;
            cnt_q   <= '0;
            hold_q  <= '0;
            lvbl_q  <= 1'b1;
            rstn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            lvbl_q  <= LVBL;
            rstn_q  <= rstn_d;
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog = ^{LVBL, wdog_clr};
    assign wdog_cnt    = '0;
    assign rstn_d      = 1'b1;

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) rstn_q <= 1'b0;
        else     rstn_q <= rstn_d;
    end
`endif

endmodule

// File: tb/tb_jtbubl_irq_wdog.sv
// Scoreboard bench for jtbubl_irq_wdog; watchdog scenarios follow JTBUBL_WDOG_EN.
module tb_jtbubl_irq_wdog;

    localparam int unsigned NIRQ = 3;
    localparam int unsigned PW   = 4;
    localparam int unsigned WW   = 8;
    localparam int unsigned HOLD = 4;

    logic            clk24    = 1'b0;
    logic            rst      = 1'b1;
    logic            cen      = 1'b0;
    logic            LVBL     = 1'b1;
    logic            wdog_clr = 1'b0;
    logic [NIRQ-1:0] irq_src  = '0;
    logic [NIRQ-1:0] irq_mode = 3'b010;
    logic [NIRQ-1:0] irq_ack  = '0;
    logic [NIRQ-1:0] irq_n;
    logic            wdog_rst_n;
    logic [WW-1:0]   wdog_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int phase = 0;

    logic [NIRQ-1:0] irq_q[$];
    logic [WW:0]     wd_q[$];

    jtbubl_irq_wdog #(
        .NIRQ(NIRQ),
        .PW  (PW),
        .WW  (WW),
        .HOLD(HOLD)
    ) dut (
        .clk24     (clk24),
        .rst       (rst),
        .cen       (cen),
        .LVBL      (LVBL),
        .wdog_clr  (wdog_clr),
        .irq_src   (irq_src),
        .irq_mode  (irq_mode),
        .irq_ack   (irq_ack),
        .irq_n     (irq_n),
        .wdog_rst_n(wdog_rst_n),
        .wdog_cnt  (wdog_cnt)
    );

    always #5 clk24 = ~clk24;

    // cen is high for every 4th rising edge
    task automatic step();
        @(posedge clk24);
        #1;
        phase = (phase + 1) % 4;
        cen   = (phase == 0);
    endtask

    task automatic align();
        while (cen !== 1'b1) step();
    endtask

    task automatic frame();
        LVBL = 1'b0;
        step();
        LVBL = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (irq_n !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_irq_n: got %b want 111", irq_n);
        end
        n_cmp++;
        if (wdog_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_cycle_rst_n: got %b want 0", wdog_rst_n);
        end
        n_cmp++;
        if (wdog_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_wdog_cnt: got %0d want 0", wdog_cnt);
        end
        step();
        n_cmp++;
        if (wdog_rst_n !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_rst_n: got %b want 1", wdog_rst_n);
        end
    endtask

    task automatic test_latched();
        logic [NIRQ-1:0] exp;
        repeat (8) step();
        align();
        irq_src[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) irq_ack[0] = 1'b1;
            irq_q.push_back((k < 4) ? 3'b110 : 3'b111);
            step();
            irq_ack[0] = 1'b0;
            exp = irq_q.pop_front();
            n_cmp++;
            if (irq_n !== exp) begin
                n_bad++;
                $display("FAIL latched k=%0d: irq_n=%b want %b", k, irq_n, exp);
            end
        end
    endtask

    task automatic test_pulse();
        logic [NIRQ-1:0] exp;
        int              end_cen;
        for (int s = 0; s < 2; s++) begin
            irq_src[1] = 1'b0;
            repeat (8) step();
            align();
            end_cen = 16;
            for (int k = 0; k < 80 + 40 * s; k++) begin
                if (k == 0)  irq_src[1] = 1'b1;
                if (k == 20) irq_src[1] = 1'b0;
                if (s == 1 && k == 40) begin
                    irq_src[1] = 1'b1;
                    end_cen    = 10 + 16;
                end
                irq_q.push_back({1'b1, ((k / 4) < end_cen) ? 1'b0 : 1'b1, 1'b1});
                step();
                exp = irq_q.pop_front();
                n_cmp++;
                if (irq_n !== exp) begin
                    n_bad++;
                    $display("FAIL pulse s=%0d k=%0d: irq_n=%b want %b", s, k, irq_n, exp);
                end
            end
        end
        irq_src[1] = 1'b0;
    endtask

    task automatic test_coincide();
        logic [NIRQ-1:0] exp;
        irq_src[0] = 1'b0;
        repeat (8) step();
        align();
        irq_src[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            irq_ack[0] = (k == 0 || k == 2);
            irq_q.push_back((k < 2) ? 3'b110 : 3'b111);
            step();
            irq_ack[0] = 1'b0;
            exp = irq_q.pop_front();
            n_cmp++;
            if (irq_n !== exp) begin
                n_bad++;
                $display("FAIL coincide k=%0d: irq_n=%b want %b", k, irq_n, exp);
            end
        end
    endtask

    task automatic test_midpulse_reset();
        logic [NIRQ-1:0] exp;
        repeat (8) step();
        align();
        irq_src[1] = 1'b1;
        repeat (6) step();
        n_cmp++;
        if (irq_n !== 3'b101) begin
            n_bad++;
            $display("FAIL midpulse_active: irq_n=%b want 101", irq_n);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (irq_n !== 3'b111 || wdog_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL midpulse_async_rst: irq_n=%b rst_n=%b want 111/0", irq_n, wdog_rst_n);
        end
        step();
        rst = 1'b0;
        // source still high after reset: must not look like a new edge
        for (int k = 0; k < 12; k++) begin
            irq_q.push_back(3'b111);
            step();
            exp = irq_q.pop_front();
            n_cmp++;
            if (irq_n !== exp) begin
                n_bad++;
                $display("FAIL no_false_edge k=%0d: irq_n=%b want %b", k, irq_n, exp);
            end
        end
        irq_src[1] = 1'b0;
    endtask

`ifdef JTBUBL_WDOG_EN
    task automatic test_wdog_fire();
        logic [WW:0] exp;
        for (int f = 1; f <= 132; f++) begin
            wdog_clr = (f >= 129 && f <= 131);
            if (f < 128)       wd_q.push_back({1'b1, WW'(f)});
            else if (f <= 131) wd_q.push_back({1'b0, WW'(128)});
            else               wd_q.push_back({1'b1, WW'(0)});
            frame();
            wdog_clr = 1'b0;
            exp = wd_q.pop_front();
            n_cmp++;
            if ({wdog_rst_n, wdog_cnt} !== exp) begin
                n_bad++;
                $display("FAIL wdog_fire f=%0d: rst_n=%b cnt=%0d want %b/%0d",
                         f, wdog_rst_n, wdog_cnt, exp[WW], exp[WW-1:0]);
            end
        end
    endtask

    task automatic test_wdog_kick();
        logic [WW:0] exp;
        for (int f = 1; f <= 129; f++) begin
            if (f < 128) begin
                wd_q.push_back({1'b1, WW'(f)});
                frame();
            end else begin
                wd_q.push_back({1'b1, WW'(f - 128)});
                LVBL = 1'b0;
                step();
                LVBL     = 1'b1;
                wdog_clr = (f == 128);
                step();
                wdog_clr = 1'b0;
            end
            exp = wd_q.pop_front();
            n_cmp++;
            if ({wdog_rst_n, wdog_cnt} !== exp) begin
                n_bad++;
                $display("FAIL wdog_kick f=%0d: rst_n=%b cnt=%0d want %b/%0d",
                         f, wdog_rst_n, wdog_cnt, exp[WW], exp[WW-1:0]);
            end
        end
    endtask
`else
    task automatic test_wdog_off();
        logic [WW:0] exp;
        for (int f = 1; f <= 300; f++) begin
            wd_q.push_back({1'b1, WW'(0)});
            frame();
            exp = wd_q.pop_front();
            n_cmp++;
            if ({wdog_rst_n, wdog_cnt} !== exp) begin
                n_bad++;
                $display("FAIL wdog_off f=%0d: rst_n=%b cnt=%0d want %b/%0d",
                         f, wdog_rst_n, wdog_cnt, exp[WW], exp[WW-1:0]);
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latched();
        test_pulse();
        test_coincide();
        test_midpulse_reset();
`ifdef JTBUBL_WDOG_EN
        test_wdog_fire();
        test_wdog_kick();
`else
        test_wdog_off();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
